// File: rtl/spi_xfer_queue.sv
// Command/response queueing stage in front of spi_master: buffers host commands,
// issues them one at a time over the PISO req/ack handshake and queues SIPO results.
module spi_xfer_queue #(
  parameter  int unsigned MAX_XFER_SIZE  = 32,
  parameter  int unsigned CMD_DEPTH      = 8,
  parameter  int unsigned RSP_DEPTH      = 8,
  localparam int unsigned XFER_CNT_WIDTH = $clog2(MAX_XFER_SIZE),
  localparam int unsigned CMD_LVL_W      = $clog2(CMD_DEPTH) + 1,
  localparam int unsigned RSP_LVL_W      = $clog2(RSP_DEPTH) + 1
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_rst,
  input  logic [MAX_XFER_SIZE-1:0]  i_cmd_data,
  input  logic [XFER_CNT_WIDTH-1:0] i_cmd_size,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  output logic [MAX_XFER_SIZE-1:0]  o_rsp_data,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [MAX_XFER_SIZE-1:0]  o_piso_data,
  output logic [XFER_CNT_WIDTH-1:0] o_piso_xfer_size,
  output logic                      o_piso_req,
  input  logic                      i_piso_ack,
  input  logic [MAX_XFER_SIZE-1:0]  i_sipo_data,
  input  logic                      i_sipo_rdy,
  output logic [CMD_LVL_W-1:0]      o_cmd_level,
  output logic [RSP_LVL_W-1:0]      o_rsp_level,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int unsigned CMD_AW = $clog2(CMD_DEPTH);
  localparam int unsigned RSP_AW = $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [MAX_XFER_SIZE-1:0]  cmd_data_mem [CMD_DEPTH];
  logic [XFER_CNT_WIDTH-1:0] cmd_size_mem [CMD_DEPTH];
  logic [MAX_XFER_SIZE-1:0]  rsp_data_mem [RSP_DEPTH];

  logic [CMD_AW-1:0]    cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CMD_LVL_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [RSP_AW-1:0]    rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [RSP_LVL_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic                 err_q, err_d;

  logic cmd_push, cmd_pop, rsp_push, rsp_pop, stray_rdy;
  logic cmd_nonempty, rsp_has_space;

  // Flow-control flags come from registered counts only
  assign o_cmd_ready   = (cmd_cnt_q != CMD_LVL_W'(CMD_DEPTH));
  assign o_rsp_valid   = (rsp_cnt_q != '0);
  assign cmd_nonempty  = (cmd_cnt_q != '0);
  assign rsp_has_space = (rsp_cnt_q < RSP_LVL_W'(RSP_DEPTH));
  assign cmd_push      = i_cmd_valid & o_cmd_ready;
  assign rsp_pop       = o_rsp_valid & i_rsp_ready;

  assign o_piso_data      = cmd_data_mem[cmd_rd_q];
  assign o_piso_xfer_size = cmd_size_mem[cmd_rd_q];
  assign o_rsp_data       = rsp_data_mem[rsp_rd_q];
  assign o_cmd_level      = cmd_cnt_q;
  assign o_rsp_level      = rsp_cnt_q;
  assign o_err            = err_q;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A transfer only launches when its response slot is already free
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_nonempty && rsp_has_space) state_d = S_REQ;
      S_REQ:   if (i_piso_ack) state_d = S_WAIT;
      S_WAIT:  if (i_sipo_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_piso_req = 1'b0;
    o_busy     = 1'b1;
    cmd_pop    = 1'b0;
    rsp_push   = 1'b0;
    stray_rdy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_busy    = 1'b0;
        stray_rdy = i_sipo_rdy;
      end
      S_REQ: begin
        o_piso_req = 1'b1;
        cmd_pop    = i_piso_ack;
        stray_rdy  = i_sipo_rdy;
      end
      S_WAIT: begin
        rsp_push = i_sipo_rdy;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  always_comb begin
    cmd_wr_d  = cmd_wr_q + CMD_AW'(cmd_push);
    cmd_rd_d  = cmd_rd_q + CMD_AW'(cmd_pop);
    cmd_cnt_d = cmd_cnt_q + CMD_LVL_W'(cmd_push) - CMD_LVL_W'(cmd_pop);
    rsp_wr_d  = rsp_wr_q + RSP_AW'(rsp_push);
    rsp_rd_d  = rsp_rd_q + RSP_AW'(rsp_pop);
    rsp_cnt_d = rsp_cnt_q + RSP_LVL_W'(rsp_push) - RSP_LVL_W'(rsp_pop);
    err_d     = err_q | stray_rdy;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cmd_wr_q  <= cmd_wr_d;
      cmd_rd_q  <= cmd_rd_d;
      cmd_cnt_q <= cmd_cnt_d;
      rsp_wr_q  <= rsp_wr_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_cnt_q <= rsp_cnt_d;
      err_q     <= err_d;
    end
  end

  // Storage arrays carry no reset; contents are qualified by the counts
  always_ff @(posedge i_sys_clk) begin
    if (cmd_push) begin
      cmd_data_mem[cmd_wr_q] <= i_cmd_data;
      cmd_size_mem[cmd_wr_q] <= i_cmd_size;
    end
    if (rsp_push) begin
      rsp_data_mem[rsp_wr_q] <= i_sipo_data;
    end
  end

endmodule
